// File: rtl/plexers_pkg.sv
// ---------------------------------------------------------------------------
// plexers_pkg
// Shared definitions for the plexers family of multiplexer blocks.
//   scan_state_t : operating state of the scanning multiplexers
//                  (OFF = output forced to zero, DIRECT = sel-driven,
//                  SCAN = autonomous round-robin)
//   clog2        : constant function giving ceil(log2(value)), minimum 0,
//                  used to size select and index fields from parameters
// ---------------------------------------------------------------------------
package plexers_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } scan_state_t;

   // Smallest number of bits able to index 'value' distinct items.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span * 2;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// ---------------------------------------------------------------------------
// mux_scan_seq
// Sequencing half of mux_scan_n: owns the operating state, the dwell counter
// and the channel index, and tells the datapath which channel to load next.
// Ports:
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   enable      : low sends the block to OFF on the next edge
//   mode        : 0 = direct select, 1 = round-robin scan
//   sel         : requested channel in direct mode (clamped to the last one)
//   dwell       : scan mode holds each channel for dwell+1 cycles
//   active_next : high when the state being entered on this edge is not OFF
//   sel_next    : channel index that will be registered on this edge
//   cur_sel     : registered channel index
//   scan_wrap   : one-cycle pulse when the scan returns from the last
//                 channel to channel 0
// ---------------------------------------------------------------------------
module mux_scan_seq
   import plexers_pkg::*;
#(
   parameter int NR_OF_INPUTS = 8,
   parameter int DWELL_BITS   = 4,
   parameter int SEL_BITS     = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  mode,
   input  logic [SEL_BITS-1:0]   sel,
   input  logic [DWELL_BITS-1:0] dwell,
   output logic                  active_next,
   output logic [SEL_BITS-1:0]   sel_next,
   output logic [SEL_BITS-1:0]   cur_sel,
   output logic                  scan_wrap
);

   localparam logic [SEL_BITS-1:0] LAST_SEL = SEL_BITS'(NR_OF_INPUTS - 1);

   scan_state_t           state;
   scan_state_t           state_next;
   logic [DWELL_BITS-1:0] cnt;
   logic [DWELL_BITS-1:0] cnt_next;
   logic                  wrap_next;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= OFF;
      end else begin
         state <= state_next;
      end
   end

   // Next state depends only on the live enable/mode pins, so any mode
   // change takes effect on the very next edge.
   always_comb begin
      state_next = OFF;
      if (enable) begin
         state_next = mode ? SCAN : DIRECT;
      end
   end

   // Next channel, counter and wrap pulse, derived from the state being
   // entered. Entering SCAN from elsewhere always restarts at channel 0.
   // The dwell comparison is live and uses >=, so lowering dwell below the
   // running count forces an advance on the next edge instead of letting
   // the counter run on and wrap.
   always_comb begin
      sel_next  = cur_sel;
      cnt_next  = '0;
      wrap_next = 1'b0;
      case (state_next)
         DIRECT: begin
            sel_next = (sel > LAST_SEL) ? LAST_SEL : sel;
         end
         SCAN: begin
            if (state != SCAN) begin
               sel_next = '0;
            end else if (cnt >= dwell) begin
               if (cur_sel >= LAST_SEL) begin
                  sel_next  = '0;
                  wrap_next = 1'b1;
               end else begin
                  sel_next = cur_sel + 1'b1;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            sel_next = cur_sel;
         end
      endcase
   end

   assign active_next = (state_next != OFF);

   // Channel index, dwell counter and wrap pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_sel   <= '0;
         cnt       <= '0;
         scan_wrap <= 1'b0;
      end else begin
         cur_sel   <= sel_next;
         cnt       <= cnt_next;
         scan_wrap <= wrap_next;
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// ---------------------------------------------------------------------------
// mux_scan_n
// Registered N-channel, W-bit multiplexer with direct select and an
// autonomous round-robin scan with programmable dwell per channel.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   enable   : low forces muxOut to zero and muxValid low
//   mode     : 0 = direct select from sel, 1 = auto-scan
//   sel      : direct-mode channel (values >= N clamp to N-1)
//   dwell    : scan-mode hold time, dwell+1 cycles per channel
//   muxIn    : flattened inputs, channel k at [k*W +: W]
//   muxOut   : registered data of channel curSel
//   muxValid : muxOut carries selected data rather than the disabled zero
//   curSel   : channel currently presented on muxOut
//   scanWrap : one-cycle pulse when the scan returns to channel 0
// ---------------------------------------------------------------------------
module mux_scan_n
   import plexers_pkg::*;
#(
   parameter  int NR_OF_INPUTS = 8,
   parameter  int NR_OF_BITS   = 1,
   parameter  int DWELL_BITS   = 4,
   localparam int SEL_BITS     = clog2(NR_OF_INPUTS)
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic                               enable,
   input  logic                               mode,
   input  logic [SEL_BITS-1:0]                sel,
   input  logic [DWELL_BITS-1:0]              dwell,
   input  logic [NR_OF_INPUTS*NR_OF_BITS-1:0] muxIn,
   output logic [NR_OF_BITS-1:0]              muxOut,
   output logic                               muxValid,
   output logic [SEL_BITS-1:0]                curSel,
   output logic                               scanWrap
);

   localparam int IDX_BITS = clog2(NR_OF_INPUTS * NR_OF_BITS);

   logic                  active_next;
   logic [SEL_BITS-1:0]   sel_next;
   logic [IDX_BITS-1:0]   base;
   logic [NR_OF_BITS-1:0] sel_data;

   mux_scan_seq #(
      .NR_OF_INPUTS (NR_OF_INPUTS),
      .DWELL_BITS   (DWELL_BITS),
      .SEL_BITS     (SEL_BITS)
   ) u_seq (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .mode        (mode),
      .sel         (sel),
      .dwell       (dwell),
      .active_next (active_next),
      .sel_next    (sel_next),
      .cur_sel     (curSel),
      .scan_wrap   (scanWrap)
   );

   // Data is picked with the index being registered on this edge, so
   // muxOut and curSel always move together and muxOut tracks live input
   // changes during a dwell.
   always_comb begin
      base     = IDX_BITS'(sel_next) * IDX_BITS'(NR_OF_BITS);
      sel_data = muxIn[base +: NR_OF_BITS];
   end

   // Output data register; OFF loads the zero and drops muxValid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         muxOut   <= '0;
         muxValid <= 1'b0;
      end else if (!active_next) begin
         muxOut   <= '0;
         muxValid <= 1'b0;
      end else begin
         muxOut   <= sel_data;
         muxValid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_n
// Self-checking bench for mux_scan_n. Three instances share the clock and
// reset: A (N=8, W=4), B (N=6, W=4, exercises the clamp) and C (N=4, W=4,
// exercises dwell=2). Channel k of every instance carries the value k+3.
// Stimulus pushes the hand-computed response for each edge into a per-instance
// queue; a monitor pops and compares one cycle-entry after each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_scan_n;

   typedef struct {
      string      name;
      logic [3:0] out;
      logic       valid;
      int         sel;
      logic       wrap;
   } exp_t;

   logic clock;
   logic reset_n;

   logic        enA, modeA, validA, wrapA;
   logic [2:0]  selA, curSelA;
   logic [3:0]  dwellA, outA;
   logic [31:0] inA;

   logic        enB, modeB, validB, wrapB;
   logic [2:0]  selB, curSelB;
   logic [3:0]  dwellB, outB;
   logic [23:0] inB;

   logic        enC, modeC, validC, wrapC;
   logic [1:0]  selC, curSelC;
   logic [3:0]  dwellC, outC;
   logic [15:0] inC;

   exp_t qA[$];
   exp_t qB[$];
   exp_t qC[$];
   exp_t monEntry;

   int testCount = 0;
   int failCount = 0;

   mux_scan_n #(.NR_OF_INPUTS(8), .NR_OF_BITS(4), .DWELL_BITS(4)) dutA (
      .clock(clock), .reset_n(reset_n), .enable(enA), .mode(modeA),
      .sel(selA), .dwell(dwellA), .muxIn(inA), .muxOut(outA),
      .muxValid(validA), .curSel(curSelA), .scanWrap(wrapA)
   );

   mux_scan_n #(.NR_OF_INPUTS(6), .NR_OF_BITS(4), .DWELL_BITS(4)) dutB (
      .clock(clock), .reset_n(reset_n), .enable(enB), .mode(modeB),
      .sel(selB), .dwell(dwellB), .muxIn(inB), .muxOut(outB),
      .muxValid(validB), .curSel(curSelB), .scanWrap(wrapB)
   );

   mux_scan_n #(.NR_OF_INPUTS(4), .NR_OF_BITS(4), .DWELL_BITS(4)) dutC (
      .clock(clock), .reset_n(reset_n), .enable(enC), .mode(modeC),
      .sel(selC), .dwell(dwellC), .muxIn(inC), .muxOut(outC),
      .muxValid(validC), .curSel(curSelC), .scanWrap(wrapC)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compares one set of DUT outputs against an expected entry.
   task automatic checkOutput(input exp_t e, input logic [3:0] o, input logic v,
                              input int s, input logic w);
      testCount++;
      if (o !== e.out || v !== e.valid || s != e.sel || w !== e.wrap) begin
         failCount++;
         $display("[TB] FAIL %s: got out=%0h valid=%0b sel=%0d wrap=%0b, want out=%0h valid=%0b sel=%0d wrap=%0b",
                  e.name, o, v, s, w, e.out, e.valid, e.sel, e.wrap);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int want);
      testCount++;
      if (got != want) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   function automatic exp_t mkExp(input string name, input logic [3:0] o,
                                  input logic v, input int s, input logic w);
      exp_t e;
      e.name  = name;
      e.out   = o;
      e.valid = v;
      e.sel   = s;
      e.wrap  = w;
      return e;
   endfunction

   task automatic pushExpected(input int inst, input exp_t e);
      case (inst)
         0:       qA.push_back(e);
         1:       qB.push_back(e);
         default: qC.push_back(e);
      endcase
   endtask

   // Queues the response for the coming edge, then moves to the next
   // falling edge where the following inputs may be driven.
   task automatic applyStimulus(input int inst, input string name, input logic [3:0] o,
                                input logic v, input int s, input logic w);
      pushExpected(inst, mkExp(name, o, v, s, w));
      @(negedge clock);
   endtask

   // Monitor: one entry per instance is consumed after every rising edge.
   always @(posedge clock) begin
      #1;
      if (qA.size() > 0) begin
         monEntry = qA.pop_front();
         checkOutput(monEntry, outA, validA, int'(curSelA), wrapA);
      end
      if (qB.size() > 0) begin
         monEntry = qB.pop_front();
         checkOutput(monEntry, outB, validB, int'(curSelB), wrapB);
      end
      if (qC.size() > 0) begin
         monEntry = qC.pop_front();
         checkOutput(monEntry, outC, validC, int'(curSelC), wrapC);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      failCount++;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      reset_n = 1'b1;
      enA = 0; modeA = 0; selA = 0; dwellA = 0;
      enB = 0; modeB = 0; selB = 0; dwellB = 0;
      enC = 0; modeC = 0; selC = 0; dwellC = 0;
      for (int k = 0; k < 8; k++) inA[k*4 +: 4] = 4'(k + 3);
      for (int k = 0; k < 6; k++) inB[k*4 +: 4] = 4'(k + 3);
      for (int k = 0; k < 4; k++) inC[k*4 +: 4] = 4'(k + 3);

      // Asynchronous reset mid-cycle, checked with no clock edge in between.
      #7 reset_n = 1'b0;
      #1;
      checkOutput(mkExp("async_reset_A", 4'h0, 1'b0, 0, 1'b0), outA, validA, int'(curSelA), wrapA);
      checkOutput(mkExp("async_reset_B", 4'h0, 1'b0, 0, 1'b0), outB, validB, int'(curSelB), wrapB);
      checkOutput(mkExp("async_reset_C", 4'h0, 1'b0, 0, 1'b0), outC, validC, int'(curSelC), wrapC);

      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pushExpected(1, mkExp("idle_B", 4'h0, 1'b0, 0, 1'b0));
         pushExpected(2, mkExp("idle_C", 4'h0, 1'b0, 0, 1'b0));
         applyStimulus(0, "idle_A", 4'h0, 1'b0, 0, 1'b0);
      end

      // Direct select on A.
      enA = 1; modeA = 0; selA = 3'd5;
      applyStimulus(0, "direct_sel5", 4'd8, 1'b1, 5, 1'b0);
      for (int s = 0; s < 8; s++) begin
         selA = 3'(s);
         applyStimulus(0, $sformatf("direct_step%0d", s), 4'(s + 3), 1'b1, s, 1'b0);
      end

      // Clamp on B (N=6): 7 and 6 both land on channel 5.
      enB = 1; modeB = 0; selB = 3'd7;
      applyStimulus(1, "clamp_sel7", 4'd8, 1'b1, 5, 1'b0);
      selB = 3'd6;
      applyStimulus(1, "clamp_sel6", 4'd8, 1'b1, 5, 1'b0);
      selB = 3'd3;
      applyStimulus(1, "clamp_sel3", 4'd6, 1'b1, 3, 1'b0);
      enB = 0;
      applyStimulus(1, "clamp_off", 4'd0, 1'b0, 3, 1'b0);

      // Scan on C with dwell=2: 0,0,0,1,1,1,2,2,2,3,3,3,0(wrap),0,0,1.
      enC = 1; modeC = 1; dwellC = 4'd2;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2, $sformatf("scan_d2_cyc%0d", i), 4'(((i / 3) % 4) + 3), 1'b1,
                       (i / 3) % 4, (i == 12));
      end
      enC = 0;

      // Scan on A with dwell=0: advance every edge, wrap every 8th.
      modeA = 1; dwellA = 4'd0;
      for (int i = 0; i < 23; i++) begin
         applyStimulus(0, $sformatf("scan_d0_cyc%0d", i), 4'((i % 8) + 3), 1'b1,
                       i % 8, (i > 0) && (i % 8 == 0));
      end

      // Mode change mid-scan while curSel=6.
      modeA = 0; selA = 3'd2;
      applyStimulus(0, "mode_to_direct", 4'd5, 1'b1, 2, 1'b0);
      modeA = 1;
      applyStimulus(0, "direct_to_scan", 4'd3, 1'b1, 0, 1'b0);
      applyStimulus(0, "scan_after_restart", 4'd4, 1'b1, 1, 1'b0);

      // Enable drop mid-scan holds curSel, then re-enable restarts at 0.
      enA = 0;
      applyStimulus(0, "enable_drop", 4'd0, 1'b0, 1, 1'b0);
      applyStimulus(0, "enable_drop_hold", 4'd0, 1'b0, 1, 1'b0);
      enA = 1; modeA = 1; dwellA = 4'd7;
      applyStimulus(0, "reenable_scan", 4'd3, 1'b1, 0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, $sformatf("dwell7_cnt%0d", i), 4'd3, 1'b1, 0, 1'b0);
      end

      // Lower dwell below the running count: advance on the next edge.
      dwellA = 4'd1;
      applyStimulus(0, "dwell_lowered", 4'd4, 1'b1, 1, 1'b0);
      applyStimulus(0, "dwell1_hold", 4'd4, 1'b1, 1, 1'b0);
      applyStimulus(0, "dwell1_adv", 4'd5, 1'b1, 2, 1'b0);

      // Asynchronous reset while A is scanning with valid data.
      #2 reset_n = 1'b0;
      #1;
      checkOutput(mkExp("async_reset_midscan", 4'h0, 1'b0, 0, 1'b0), outA, validA, int'(curSelA), wrapA);
      @(negedge clock);
      enA = 0;
      reset_n = 1'b1;
      @(negedge clock);

      checkValue("queues_drained", qA.size() + qB.size() + qC.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Successor to the fixed 8:1 single-bit enable mux in the plexers library.
- Adds two operating modes:
  - Direct select from `sel`.
  - Autonomous round-robin scan through all channels, with a programmable dwell time per channel.
- Used wherever a datapath must time-share one consumer (display driver, serial framer, probe bus) across several sources.

Parameters:
- NR_OF_INPUTS, 8: number of channels N; legal range 2..64.
- NR_OF_BITS, 1: width W of each channel.
- DWELL_BITS, 4: width of the dwell-count input.
- SEL_BITS: derived localparam, ceil(log2(NR_OF_INPUTS)); not overridable.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; low forces output to zero.
- mode  in  1  0 = direct select, 1 = auto-scan.
- sel  in  SEL_BITS  channel select, used in direct mode.
- dwell  in  DWELL_BITS  scan mode: each channel is held for dwell+1 cycles.
- muxIn  in  NR_OF_INPUTS*NR_OF_BITS  flattened inputs; channel k occupies bits [k*W+W-1 : k*W].
- muxOut  out  NR_OF_BITS  registered selected data.
- muxValid  out  1  muxOut holds selected data (not the disabled zero).
- curSel  out  SEL_BITS  channel index currently presented on muxOut.
- scanWrap  out  1  one-cycle pulse when the scan completes channel N-1 and returns to 0.

Behaviour:
- Reset (reset_n low, asynchronous): muxOut=0, muxValid=0, curSel=0, scanWrap=0, dwell counter=0, state=OFF. The block leaves reset on the first rising clock edge after reset_n goes high.
- States: OFF, DIRECT, SCAN. Next state is evaluated every edge:
  - enable=0 -> OFF.
  - enable=1, mode=0 -> DIRECT.
  - enable=1, mode=1 -> SCAN.
- Output register: muxOut and curSel update on the same edge, so muxOut always equals muxIn[curSel] as sampled at that edge. Latency from any input change to muxOut is 1 cycle.
- OFF:
  - muxOut <= 0, muxValid <= 0, scanWrap <= 0, dwell counter <= 0.
  - curSel holds its value.
- DIRECT:
  - curSel <= sel. If sel >= NR_OF_INPUTS, clamp to NR_OF_INPUTS-1; this mirrors the default branch of the legacy mux.
  - muxOut <= selected channel, muxValid <= 1, scanWrap <= 0, dwell counter <= 0.
- Entering SCAN from OFF or DIRECT: curSel <= 0, counter <= 0, muxOut <= muxIn ch0, muxValid <= 1.
- Within SCAN:
  - If counter >= dwell: counter <= 0 and curSel advances by 1.
  - Otherwise counter increments and curSel holds.
  - muxOut <= muxIn[next curSel] every cycle, so live data tracks input changes within a dwell.
- Wrap: advancing from curSel=N-1 goes to 0 and sets scanWrap=1 for exactly that cycle. scanWrap is 0 in every other cycle.
- dwell=0: advance every cycle, so a full scan takes N cycles.
- dwell is compared live. If it is lowered mid-dwell so that counter >= dwell, the advance happens on the next edge. The counter never wraps past dwell.
- Mode 1->0 mid-scan: DIRECT takes effect on the next edge and the counter clears.
- enable drop mid-scan: OFF on the next edge. Re-enabling in scan mode restarts at channel 0.
- Non-power-of-two N: scan sequence is 0..N-1 only. Out-of-range indices never appear on curSel.
- Asynchronous reset asserted mid-scan: all outputs go to their reset values immediately, with no clock required.

Decomposition:
- Shared package plexers_pkg holds:
  - The state encoding localparams (OFF=2'd0, DIRECT=2'd1, SCAN=2'd2).
  - A clog2 constant function reused by other plexers.
- One natural sub-module, mux_scan_seq: state register, dwell counter, curSel/scanWrap generation.
- The top level keeps the N:1 data select (index-based part-select) and the muxOut/muxValid register.

Test Plan:
- Reset release: assert reset_n=0 mid-cycle -> outputs 0 immediately. Release, hold enable=0 for 3 cycles -> muxOut=0, muxValid=0, curSel=0.
- Direct select, N=8, W=4, channel k = k+3: enable=1, mode=0, sel=5 -> one cycle later muxOut=8, curSel=5, muxValid=1. Step sel 0..7 -> each value is seen one cycle later.
- Clamp, N=6: sel=7 -> curSel=5, muxOut=ch5.
- Scan with dwell=2, N=4:
  - curSel sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - scanWrap is high only in the cycle where curSel first returns to 0.
  - Period is 12 cycles.
- Dwell=0, N=8 -> curSel increments every cycle and scanWrap fires every 8th cycle. Change dwell from 7 to 1 while counter=5 -> advance on the next edge.
- Interruptions:
  - mode 1->0 with sel=2 while curSel=6 -> next cycle curSel=2.
  - enable low during scan -> next cycle muxOut=0, muxValid=0, curSel held.
  - Re-enable with mode=1 -> curSel=0.
